au_neg_sched: RTL and testbench

Round-robin scheduler that shares one AU_neg datapath instance among NREQ requesters. Each requester offers an operand over a valid/ready handshake. The block grants one requester per cycle, negates the operand through the shared AU_neg, and returns the result with the requester ID through a one-slot registered response stage with backpressure. It sits between multiple producer lanes and a single arithmetic-unit consumer.

---
 rtl/au_pkg.sv | 17 +
 rtl/au_neg.sv | 18 +
 rtl/au_rr_arb.sv | 37 +++
 rtl/au_neg_sched.sv | 147 ++++++++++++++
 tb/tb_au_neg_sched.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/au_pkg.sv
// Shared types and helpers for the AU_neg scheduler slice.
package au_pkg;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/au_neg.sv
// Two's-complement negation datapath; ARCH picks invert-and-increment or subtract-from-zero.
module AU_neg #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  generate
    if (ARCH == 0) begin : g_inv_inc
      assign y = ~a + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin : g_sub
      assign y = {WIDTH{1'b0}} - a;
    end
  endgenerate

endmodule

// File: rtl/au_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module au_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  // Rotating priority search starting at ptr.
  always_comb begin
    int idx_s;
    gnt     = {NREQ{1'b0}};
    gnt_idx = {IDW{1'b0}};
    gnt_any = 1'b0;
    idx_s   = 0;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx_s = (int'(ptr) + k) % NREQ;
        if (!gnt_any && req[idx_s]) begin
          gnt[idx_s] = 1'b1;
          gnt_idx    = IDW'(idx_s);
          gnt_any    = 1'b1;
        end else begin
          gnt_any = gnt_any;
        end
      end
    end else begin
      gnt_any = 1'b0;
    end
  end

endmodule

// File: rtl/au_neg_sched.sv
// Round-robin scheduler sharing one AU_neg among NREQ requesters with a one-slot response register.
// Optional AU_NEG_SCHED_OVF_EN adds rsp_ovf, flagging the unrepresentable negation of the most negative value.
module au_neg_sched
  import au_pkg::*;
#(
  parameter int   WIDTH = 8,
  parameter int   ARCH  = 0,
  parameter int   NREQ  = 4,
  localparam int  IDW   = clog2_min1(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
`ifdef AU_NEG_SCHED_OVF_EN
  output logic                  rsp_ovf,
`endif
  output logic [IDW-1:0]        rsp_id
);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [IDW-1:0]    ptr_r;
  logic [IDW-1:0]    ptr_nxt_s;
  logic              can_accept_s;
  logic              rsp_valid_s;
  logic [NREQ-1:0]   gnt_s;
  logic [IDW-1:0]    gnt_idx_s;
  logic              gnt_any_s;
  logic [WIDTH-1:0]  mux_data_s;
  logic [WIDTH-1:0]  neg_data_s;
  logic [WIDTH-1:0]  rsp_data_r;
  logic [IDW-1:0]    rsp_id_r;

  au_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_r),
    .en      (can_accept_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .gnt_any (gnt_any_s)
  );

  // One-hot operand mux; lanes without a grant never reach the datapath.
  always_comb begin
    mux_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_s[i]) begin
        mux_data_s = mux_data_s | req_data[i*WIDTH +: WIDTH];
      end else begin
        mux_data_s = mux_data_s;
      end
    end
  end

  AU_neg #(
    .WIDTH (WIDTH),
    .ARCH  (ARCH)
  ) u_neg (
    .a (mux_data_s),
    .y (neg_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a grant always (re)fills the slot, a drain alone empties it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_EMPTY: begin
        if (gnt_any_s) state_nxt_s = S_FULL;
        else           state_nxt_s = S_EMPTY;
      end
      S_FULL: begin
        if (gnt_any_s)      state_nxt_s = S_FULL;
        else if (rsp_ready) state_nxt_s = S_EMPTY;
        else                state_nxt_s = S_FULL;
      end
      default: state_nxt_s = S_EMPTY;
    endcase
  end

  // FSM outputs: the slot may be refilled while it is being drained.
  always_comb begin
    rsp_valid_s  = (state_r == S_FULL);
    can_accept_s = (state_r == S_EMPTY) | (rsp_ready & rsp_valid_s);
    if (gnt_idx_s == IDW'(NREQ - 1)) begin
      ptr_nxt_s = {IDW{1'b0}};
    end else begin
      ptr_nxt_s = gnt_idx_s + IDW'(1'b1);
    end
  end

  // Response register and pointer; both only move on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_r <= {WIDTH{1'b0}};
      rsp_id_r   <= {IDW{1'b0}};
      ptr_r      <= {IDW{1'b0}};
    end else if (gnt_any_s) begin
      rsp_data_r <= neg_data_s;
      rsp_id_r   <= gnt_idx_s;
      ptr_r      <= ptr_nxt_s;
    end else begin
      rsp_data_r <= rsp_data_r;
      rsp_id_r   <= rsp_id_r;
      ptr_r      <= ptr_r;
    end
  end

`ifdef AU_NEG_SCHED_OVF_EN
  logic rsp_ovf_r;

  // Overflow flag registered alongside the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_ovf_r <= 1'b0;
    end else if (gnt_any_s) begin
      rsp_ovf_r <= (mux_data_s == {1'b1, {(WIDTH-1){1'b0}}});
    end else begin
      rsp_ovf_r <= rsp_ovf_r;
    end
  end

  assign rsp_ovf = rsp_ovf_r;
`endif

  assign req_ready = gnt_s;
  assign rsp_valid = rsp_valid_s;
  assign rsp_data  = rsp_data_r;
  assign rsp_id    = rsp_id_r;

endmodule

// File: tb/tb_au_neg_sched.sv
// Self-checking bench for au_neg_sched (WIDTH=8, NREQ=4, ARCH=0) with a cycle-level reference model.
module tb_au_neg_sched;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic             clk;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [1:0]       rsp_id;
`ifdef AU_NEG_SCHED_OVF_EN
  logic             rsp_ovf;
  logic             m_ovf;
`endif

  int n_checks;
  int n_fail;

  // Reference model state: one response slot, rotating pointer, per-lane outstanding operands.
  logic             m_full;
  logic [WIDTH-1:0] m_data;
  int               m_id;
  int               m_ptr;
  logic [WIDTH-1:0] lane_q [NREQ][$];
  int               wait_cnt [NREQ];
  int               n_granted;
  int               n_consumed;

  au_neg_sched #(.WIDTH(WIDTH), .ARCH(0), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
`ifdef AU_NEG_SCHED_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] neg_ref(input logic [WIDTH-1:0] a);
    return WIDTH'(0 - int'(a));
  endfunction

  task automatic model_reset();
    m_full = 1'b0; m_data = 8'h00; m_id = 0; m_ptr = 0;
`ifdef AU_NEG_SCHED_OVF_EN
    m_ovf = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      lane_q[i].delete();
      wait_cnt[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 4'b0000; req_data = 32'h0; rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: check outputs against the model at negedge, update the model at posedge.
  task automatic step(output int g);
    logic [NREQ-1:0]  exp_rdy;
    logic [WIDTH-1:0] op;
    int id;
    @(negedge clk);
    g = -1;
    if (!m_full || rsp_ready) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    exp_rdy = 4'b0000;
    if (g >= 0) exp_rdy[g] = 1'b1;
    n_checks++;
    if (req_ready !== exp_rdy) begin
      n_fail++; $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
    end
    n_checks++;
    if (rsp_valid !== m_full) begin
      n_fail++; $display("FAIL rsp_valid: got %b expected %b", rsp_valid, m_full);
    end
    n_checks++;
    if (rsp_data !== m_data || rsp_id !== 2'(m_id)) begin
      n_fail++; $display("FAIL rsp_hold: got data=%h id=%0d expected data=%h id=%0d", rsp_data, rsp_id, m_data, m_id);
    end
`ifdef AU_NEG_SCHED_OVF_EN
    n_checks++;
    if (rsp_ovf !== m_ovf) begin
      n_fail++; $display("FAIL rsp_ovf: got %b expected %b", rsp_ovf, m_ovf);
    end
`endif
    if (rsp_valid === 1'b1 && rsp_ready) begin
      n_checks++;
      if ($isunknown(rsp_id) || lane_q[int'(rsp_id)].size() == 0) begin
        n_fail++; $display("FAIL dup_or_stray: response id=%0d data=%h with nothing outstanding", rsp_id, rsp_data);
      end else begin
        id = int'(rsp_id);
        op = lane_q[id].pop_front();
        n_consumed++;
        if (rsp_data !== neg_ref(op)) begin
          n_fail++; $display("FAIL lane_order: id=%0d got %h expected %h", id, rsp_data, neg_ref(op));
        end
      end
    end
    @(posedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (g == i) begin
        n_checks++;
        if (wait_cnt[i] > NREQ) begin
          n_fail++; $display("FAIL fairness: lane %0d waited %0d grants, limit %0d", i, wait_cnt[i], NREQ);
        end
        wait_cnt[i] = 0;
      end else if (req_valid[i] && g >= 0) begin
        wait_cnt[i]++;
      end else if (!req_valid[i]) begin
        wait_cnt[i] = 0;
      end
    end
    if (g >= 0) begin
      op = req_data[g*WIDTH +: WIDTH];
      lane_q[g].push_back(op);
      m_data = neg_ref(op); m_id = g; m_full = 1'b1; m_ptr = (g + 1) % NREQ;
`ifdef AU_NEG_SCHED_OVF_EN
      m_ovf = (op == 8'h80);
`endif
      n_granted++;
    end else if (m_full && rsp_ready) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    int g;
    rst_n = 1'b0; req_valid = 4'b0000; rsp_ready = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_values: valid=%b data=%h id=%0d ready=%b expected 0/00/0/0000", rsp_valid, rsp_data, rsp_id, req_ready);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    step(g);
  endtask

  task automatic test_single();
    int g;
    do_reset();
    req_valid = 4'b0001; req_data = {8'hxx, 8'hxx, 8'hxx, 8'h05}; rsp_ready = 1'b1;
    step(g);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hFB || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL single: valid=%b data=%h id=%0d expected 1/fb/0", rsp_valid, rsp_data, rsp_id);
    end
    req_valid = 4'b0000;
    step(g);
    req_valid = 4'b1111; req_data = 32'h44332211;
    step(g);
    n_checks++;
    if (g != 1) begin
      n_fail++; $display("FAIL ptr_after_single: granted %0d expected 1", g);
    end
  endtask

  task automatic test_round_robin();
    int g;
    int exp_g [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req_valid = 4'b1111; req_data = 32'h40302010; rsp_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step(g);
      n_checks++;
      if (g != exp_g[j] || rsp_valid !== 1'b1) begin
        n_fail++; $display("FAIL round_robin: cycle %0d granted %0d valid=%b expected %0d/1", j, g, rsp_valid, exp_g[j]);
      end
    end
  endtask

  task automatic test_backpressure();
    int g;
    do_reset();
    req_valid = 4'b0100; req_data = {8'h11, 8'h80, 8'h22, 8'h33}; rsp_ready = 1'b0;
    step(g);
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      step(g);
      n_checks++;
      if (rsp_data !== 8'h80 || rsp_id !== 2'd2 || req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL backpressure: data=%h id=%0d ready=%b expected 80/2/0000", rsp_data, rsp_id, req_ready);
      end
    end
    rsp_ready = 1'b1;
    step(g);
    n_checks++;
    if (g != 3 || rsp_valid !== 1'b1 || rsp_data !== 8'hEF || rsp_id !== 2'd3) begin
      n_fail++; $display("FAIL refill: grant=%0d valid=%b data=%h id=%0d expected 3/1/ef/3", g, rsp_valid, rsp_data, rsp_id);
    end
  endtask

  task automatic test_boundaries();
    int g;
    logic [7:0] ops  [4] = '{8'h00, 8'h80, 8'hFF, 8'h01};
    logic [7:0] exps [4] = '{8'h00, 8'h80, 8'h01, 8'hFF};
    do_reset();
    rsp_ready = 1'b1; req_valid = 4'b0001;
    for (int j = 0; j < 4; j++) begin
      req_data = {24'hxxxxxx, ops[j]};
      step(g);
      n_checks++;
      if (rsp_data !== exps[j]) begin
        n_fail++; $display("FAIL boundary: operand %h got %h expected %h", ops[j], rsp_data, exps[j]);
      end
`ifdef AU_NEG_SCHED_OVF_EN
      n_checks++;
      if (rsp_ovf !== (j == 1)) begin
        n_fail++; $display("FAIL boundary_ovf: operand %h got %b expected %b", ops[j], rsp_ovf, (j == 1));
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int g;
    do_reset();
    req_valid = 4'b1000; req_data = 32'h7F000000; rsp_ready = 1'b0;
    step(g);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL async_reset: valid=%b data=%h id=%0d expected 0/00/0", rsp_valid, rsp_data, rsp_id);
    end
    model_reset();
    req_valid = 4'b0000;
    @(posedge clk); #1 rst_n = 1'b1;
    step(g);
    req_valid = 4'b1111; req_data = 32'h0A0B0C0D; rsp_ready = 1'b1;
    step(g);
    n_checks++;
    if (g != 0) begin
      n_fail++; $display("FAIL first_grant_after_reset: granted %0d expected 0", g);
    end
  endtask

  task automatic test_random();
    int g;
    do_reset();
    n_granted = 0; n_consumed = 0;
    for (int c = 0; c < 10000; c++) begin
      step(g);
      for (int i = 0; i < NREQ; i++) begin
        if (g == i || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 9) < 6);
          req_data[i*WIDTH +: WIDTH] = 8'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = 4'b0000; rsp_ready = 1'b1;
    repeat (3) step(g);
    n_checks++;
    if (n_granted != n_consumed || m_full !== 1'b0) begin
      n_fail++; $display("FAIL conservation: granted %0d consumed %0d expected equal", n_granted, n_consumed);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_granted = 0; n_consumed = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
